// File: rtl/pitch_ctrl_pkg.sv
// Shared definitions for the pitch shifter control front-end: sequencer
// states, register map, CTRL/STATUS bit positions and the reset factor.
package pitch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_PS = 3'd2,
        ST_EMIT    = 3'd3,
        ST_FLUSH   = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_FACTOR = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_BYPASS_BIT    = 1;
    localparam int CTRL_MIX_BIT       = 2;
    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_OVERRUN_BIT = 1;
    localparam int STATUS_TIMEOUT_BIT = 2;

    // Factor register is unsigned Q2.29
    localparam int          FACTOR_BITS    = 31;
    localparam logic [31:0] DEFAULT_FACTOR = 32'h1E00_0000;

endpackage

// File: rtl/pitch_ctrl_regs.sv
// Avalon-MM register file for the pitch shifter controller: CTRL, pending
// FACTOR with its pending flag, sticky W1C STATUS flags and the sample COUNT.
// Optional feature macro: PITCH_CTRL_MIX_EN makes CTRL bit2 (mix) writable;
// without it the bit stays 0.
module pitch_ctrl_regs
    import pitch_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             avs_address,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    output logic [31:0]            avs_readdata,
    input  logic                   busy,
    input  logic                   count_inc,
    input  logic                   overrun_set,
    input  logic                   timeout_set,
    input  logic                   factor_clr,
    output logic                   ctrl_enable,
    output logic                   ctrl_bypass,
    output logic                   ctrl_mix,
    output logic [FACTOR_BITS-1:0] factor_value,
    output logic                   factor_pending
);

    logic [2:0]             ctrl_r;
    logic [FACTOR_BITS-1:0] factor_r;
    logic                   pending_r;
    logic                   overrun_r;
    logic                   timeout_r;
    logic [31:0]            count_r;
    logic                   wr_ctrl_s;
    logic                   wr_factor_s;
    logic                   wr_status_s;
    logic                   wr_count_s;
    logic                   unused_ok_s;

    assign unused_ok_s    = avs_writedata[31];
    assign ctrl_enable    = ctrl_r[CTRL_ENABLE_BIT];
    assign ctrl_bypass    = ctrl_r[CTRL_BYPASS_BIT];
    assign ctrl_mix       = ctrl_r[CTRL_MIX_BIT];
    assign factor_value   = factor_r;
    assign factor_pending = pending_r;

    // Decode the write strobe into one enable per register
    always_comb begin
        wr_ctrl_s   = 1'b0;
        wr_factor_s = 1'b0;
        wr_status_s = 1'b0;
        wr_count_s  = 1'b0;
        if (avs_write) begin
            case (avs_address)
                ADDR_CTRL:   wr_ctrl_s   = 1'b1;
                ADDR_FACTOR: wr_factor_s = 1'b1;
                ADDR_STATUS: wr_status_s = 1'b1;
                ADDR_COUNT:  wr_count_s  = 1'b1;
                default:     wr_ctrl_s   = 1'b0;
            endcase
        end else begin
            wr_ctrl_s = 1'b0;
        end
    end

    // CTRL storage; the mix bit only exists when the mix feature is built in
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r <= 3'b000;
        end else if (wr_ctrl_s) begin
            ctrl_r[CTRL_ENABLE_BIT] <= avs_writedata[CTRL_ENABLE_BIT];
            ctrl_r[CTRL_BYPASS_BIT] <= avs_writedata[CTRL_BYPASS_BIT];
`ifdef PITCH_CTRL_MIX_EN
            ctrl_r[CTRL_MIX_BIT]    <= avs_writedata[CTRL_MIX_BIT];
`endif
        end
    end

    // Pending factor; a write in the same cycle as a flush keeps it pending
    always_ff @(posedge clk) begin
        if (rst) begin
            factor_r  <= DEFAULT_FACTOR[FACTOR_BITS-1:0];
            pending_r <= 1'b0;
        end else if (wr_factor_s) begin
            factor_r  <= avs_writedata[FACTOR_BITS-1:0];
            pending_r <= 1'b1;
        end else if (factor_clr) begin
            pending_r <= 1'b0;
        end
    end

    // Sticky STATUS flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            overrun_r <= overrun_set |
                         (overrun_r & ~(wr_status_s & avs_writedata[STATUS_OVERRUN_BIT]));
            timeout_r <= timeout_set |
                         (timeout_r & ~(wr_status_s & avs_writedata[STATUS_TIMEOUT_BIT]));
        end
    end

    // Completed shifted sample counter; wraps, any write clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (wr_count_s) begin
            count_r <= 32'd0;
        end else if (count_inc) begin
            count_r <= count_r + 32'd1;
        end
    end

    // Registered read mux, data valid the cycle after the read strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            avs_readdata <= 32'd0;
        end else if (avs_read) begin
            case (avs_address)
                ADDR_CTRL:   avs_readdata <= {29'd0, ctrl_r};
                ADDR_FACTOR: avs_readdata <= {1'b0, factor_r};
                ADDR_STATUS: avs_readdata <= {29'd0, timeout_r, overrun_r, busy};
                ADDR_COUNT:  avs_readdata <= count_r;
                default:     avs_readdata <= 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/pitch_shift_ctrl.sv
// Pitch shifter sequencer: one shifter transaction per stereo ADC sample,
// with mute/bypass paths, result timeout, overrun detection and factor
// updates applied through a two-cycle shifter flush between samples.
// Optional feature macro: PITCH_CTRL_MIX_EN (wet/dry 50% mix on CTRL bit2).
module pitch_shift_ctrl
    import pitch_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 24,
    parameter int FACTOR_W  = 31,
    parameter int TIMEOUT   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  avs_address,
    input  logic                        avs_read,
    input  logic                        avs_write,
    input  logic [31:0]                 avs_writedata,
    output logic [31:0]                 avs_readdata,
    input  logic signed [DATA_SIZE-1:0] adc_left,
    input  logic signed [DATA_SIZE-1:0] adc_right,
    input  logic                        adc_valid,
    output logic signed [DATA_SIZE-1:0] dac_left,
    output logic signed [DATA_SIZE-1:0] dac_right,
    output logic                        dac_valid,
    output logic signed [DATA_SIZE-1:0] ps_in_left,
    output logic signed [DATA_SIZE-1:0] ps_in_right,
    output logic                        ps_in_ready,
    input  logic signed [DATA_SIZE-1:0] ps_out_left,
    input  logic signed [DATA_SIZE-1:0] ps_out_right,
    input  logic                        ps_out_ready,
    output logic                        ps_rst,
    output logic [FACTOR_W-1:0]         shift_factor
);

    localparam int               CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                   state_r;
    logic [CNT_W-1:0]         wait_cnt_r;
    logic                     flush_second_r;
    logic                     ctrl_enable_s;
    logic                     ctrl_bypass_s;
    logic                     ctrl_mix_s;
    logic [FACTOR_BITS-1:0]   factor_value_s;
    logic                     factor_pending_s;
    logic                     busy_s;
    logic                     timed_out_s;
    logic signed [DATA_SIZE-1:0] emit_left_s;
    logic signed [DATA_SIZE-1:0] emit_right_s;

    assign busy_s      = (state_r != ST_IDLE);
    assign timed_out_s = (state_r == ST_WAIT_PS) && !ps_out_ready && (wait_cnt_r == WAIT_LAST);
    // The shifter must be held in reset for the whole controller reset too
    assign ps_rst      = rst | (state_r == ST_FLUSH);

    pitch_ctrl_regs u_regs (
        .clk            (clk),
        .rst            (rst),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .busy           (busy_s),
        .count_inc      (state_r == ST_EMIT),
        .overrun_set    (adc_valid && busy_s),
        .timeout_set    (timed_out_s),
        .factor_clr     ((state_r == ST_FLUSH) && !flush_second_r),
        .ctrl_enable    (ctrl_enable_s),
        .ctrl_bypass    (ctrl_bypass_s),
        .ctrl_mix       (ctrl_mix_s),
        .factor_value   (factor_value_s),
        .factor_pending (factor_pending_s)
    );

    // Output sample: wet result, or half-wet plus half-dry when mixing
    always_comb begin
        if (ctrl_mix_s) begin
            emit_left_s  = (ps_out_left  >>> 1'b1) + (ps_in_left  >>> 1'b1);
            emit_right_s = (ps_out_right >>> 1'b1) + (ps_in_right >>> 1'b1);
        end else begin
            emit_left_s  = ps_out_left;
            emit_right_s = ps_out_right;
        end
    end

    // Sample sequencer with registered shifter/DAC outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            wait_cnt_r     <= {CNT_W{1'b0}};
            flush_second_r <= 1'b0;
            ps_in_left     <= {DATA_SIZE{1'b0}};
            ps_in_right    <= {DATA_SIZE{1'b0}};
            ps_in_ready    <= 1'b0;
            dac_left       <= {DATA_SIZE{1'b0}};
            dac_right      <= {DATA_SIZE{1'b0}};
            dac_valid      <= 1'b0;
            shift_factor   <= FACTOR_W'(DEFAULT_FACTOR);
        end else begin
            dac_valid   <= 1'b0;
            ps_in_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (adc_valid) begin
                        if (!ctrl_enable_s) begin
                            dac_left  <= {DATA_SIZE{1'b0}};
                            dac_right <= {DATA_SIZE{1'b0}};
                            dac_valid <= 1'b1;
                        end else if (ctrl_bypass_s) begin
                            dac_left  <= adc_left;
                            dac_right <= adc_right;
                            dac_valid <= 1'b1;
                        end else begin
                            ps_in_left  <= adc_left;
                            ps_in_right <= adc_right;
                            ps_in_ready <= 1'b1;
                            wait_cnt_r  <= {CNT_W{1'b0}};
                            state_r     <= ST_ISSUE;
                        end
                    end else if (factor_pending_s) begin
                        flush_second_r <= 1'b0;
                        state_r        <= ST_FLUSH;
                    end
                end
                ST_ISSUE: begin
                    // Counter keeps running so the timeout is measured from ps_in_ready
                    wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_r    <= ST_WAIT_PS;
                end
                ST_WAIT_PS: begin
                    if (ps_out_ready) begin
                        dac_left  <= emit_left_s;
                        dac_right <= emit_right_s;
                        dac_valid <= 1'b1;
                        state_r   <= ST_EMIT;
                    end else if (timed_out_s) begin
                        dac_left       <= ps_in_left;
                        dac_right      <= ps_in_right;
                        dac_valid      <= 1'b1;
                        flush_second_r <= 1'b0;
                        state_r        <= ST_FLUSH;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_EMIT: begin
                    flush_second_r <= 1'b0;
                    state_r        <= factor_pending_s ? ST_FLUSH : ST_IDLE;
                end
                ST_FLUSH: begin
                    if (!flush_second_r) begin
                        shift_factor   <= FACTOR_W'(factor_value_s);
                        flush_second_r <= 1'b1;
                    end else begin
                        flush_second_r <= 1'b0;
                        state_r        <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pitch_shift_ctrl.sv
// Self-checking bench for pitch_shift_ctrl: a behavioural shifter model
// answering k cycles after ps_in_ready, and a scoreboard of expected DAC
// samples and ps_in_ready events with the cycle each must appear in.
module tb_pitch_shift_ctrl;

    localparam int DATA_SIZE = 24;
    localparam int FACTOR_W  = 31;
    localparam int TIMEOUT   = 64;
`ifdef PITCH_CTRL_MIX_EN
    localparam bit MIX_EN = 1'b1;
`else
    localparam bit MIX_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic [1:0]           avs_address;
    logic                 avs_read;
    logic                 avs_write;
    logic [31:0]          avs_writedata;
    logic [31:0]          avs_readdata;
    logic [DATA_SIZE-1:0] adc_left, adc_right;
    logic                 adc_valid;
    logic [DATA_SIZE-1:0] dac_left, dac_right;
    logic                 dac_valid;
    logic [DATA_SIZE-1:0] ps_in_left, ps_in_right;
    logic                 ps_in_ready;
    logic [DATA_SIZE-1:0] ps_out_left, ps_out_right;
    logic                 ps_out_ready;
    logic                 ps_rst;
    logic [FACTOR_W-1:0]  shift_factor;

    pitch_shift_ctrl #(.DATA_SIZE(DATA_SIZE), .FACTOR_W(FACTOR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .adc_left(adc_left), .adc_right(adc_right), .adc_valid(adc_valid),
        .dac_left(dac_left), .dac_right(dac_right), .dac_valid(dac_valid),
        .ps_in_left(ps_in_left), .ps_in_right(ps_in_right), .ps_in_ready(ps_in_ready),
        .ps_out_left(ps_out_left), .ps_out_right(ps_out_right), .ps_out_ready(ps_out_ready),
        .ps_rst(ps_rst), .shift_factor(shift_factor)
    );

    typedef struct {
        logic [47:0] val;
        int          cyc;
    } exp_t;

    exp_t dac_q[$];
    exp_t pir_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference state
    bit   m_en, m_byp, m_mix, sh_dead;
    int   sh_k = 4;
    int   free_cyc = 0;
    bit   exp_ovr, exp_to;
    int   exp_count = 0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Shifter behaviour: left halved (arithmetic), right inverted
    function automatic logic [47:0] wet_of(input logic [23:0] l, input logic [23:0] r);
        logic signed [23:0] ls;
        ls = l;
        return {ls >>> 1, ~r};
    endfunction

    function automatic logic [23:0] mix1(input logic [23:0] w, input logic [23:0] d);
        logic signed [23:0] ws, ds;
        ws = w;
        ds = d;
        return (ws >>> 1) + (ds >>> 1);
    endfunction

    // Monitor plus shifter model, both mid-cycle
    initial begin : monitor
        exp_t        e;
        bit          busy_m;
        int          due;
        logic [47:0] held;
        busy_m = 1'b0;
        due = 0;
        held = 48'd0;
        ps_out_ready = 1'b0;
        ps_out_left = 24'd0;
        ps_out_right = 24'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_m = 1'b0;
                ps_out_ready = 1'b0;
            end else begin
                if (dac_valid) begin
                    if (dac_q.size() == 0) begin
                        check_eq("dac_extra", 64'(dac_valid), 64'd0);
                    end else begin
                        e = dac_q.pop_front();
                        check_eq("dac_val", 64'({dac_left, dac_right}), 64'(e.val));
                        check_eq("dac_cyc", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (ps_in_ready) begin
                    if (pir_q.size() == 0) begin
                        check_eq("pir_extra", 64'(ps_in_ready), 64'd0);
                    end else begin
                        e = pir_q.pop_front();
                        check_eq("pir_val", 64'({ps_in_left, ps_in_right}), 64'(e.val));
                        check_eq("pir_cyc", 64'(cyc), 64'(e.cyc));
                    end
                end
                ps_out_ready = 1'b0;
                if (ps_in_ready && !sh_dead) begin
                    busy_m = 1'b1;
                    due = cyc + sh_k;
                    held = wet_of(ps_in_left, ps_in_right);
                end
                if (busy_m && cyc == due) begin
                    ps_out_ready = 1'b1;
                    {ps_out_left, ps_out_right} = held;
                    busy_m = 1'b0;
                end
            end
        end
    end

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic set_ctrl(input bit en, input bit byp, input bit mx);
        avs_wr(2'd0, {29'd0, mx, byp, en});
        m_en = en;
        m_byp = byp;
        m_mix = mx;
    endtask

    // Drive one ADC pulse (optionally with a FACTOR write) and predict its fate
    task automatic send(input logic [23:0] l, input logic [23:0] r, input bit fwr,
                        input logic [31:0] fdata, output int t_out);
        exp_t        e;
        exp_t        p;
        logic [47:0] w;
        int          t;
        @(negedge clk);
        t = cyc;
        t_out = t;
        adc_left = l;
        adc_right = r;
        adc_valid = 1'b1;
        if (fwr) begin
            avs_address = 2'd1;
            avs_writedata = fdata;
            avs_write = 1'b1;
        end
        if (t < free_cyc) begin
            exp_ovr = 1'b1;
        end else if (!m_en) begin
            e.val = 48'd0;
            e.cyc = t + 1;
            dac_q.push_back(e);
            free_cyc = t + 1;
        end else if (m_byp) begin
            e.val = {l, r};
            e.cyc = t + 1;
            dac_q.push_back(e);
            free_cyc = t + 1;
        end else begin
            p.val = {l, r};
            p.cyc = t + 1;
            pir_q.push_back(p);
            if (sh_dead) begin
                e.val = {l, r};
                e.cyc = t + 1 + TIMEOUT;
                exp_to = 1'b1;
                free_cyc = t + TIMEOUT + 3;
            end else begin
                w = wet_of(l, r);
                if (m_mix && MIX_EN) e.val = {mix1(w[47:24], l), mix1(w[23:0], r)};
                else                 e.val = w;
                e.cyc = t + 2 + sh_k;
                exp_count++;
                free_cyc = t + 3 + sh_k + (fwr ? 2 : 0);
            end
            dac_q.push_back(e);
        end
        @(negedge clk);
        adc_valid = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < free_cyc + 1) @(negedge clk);
    endtask

    task automatic chk_status(input string tag);
        logic [31:0] d;
        avs_rd(2'd2, d);
        check_eq(tag, 64'(d), 64'({29'd0, exp_to, exp_ovr, 1'b0}));
    endtask

    initial begin : stim
        logic [31:0] d;
        logic [23:0] l, r;
        int          t, g, mode, guard;

        rst = 1'b1;
        avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
        adc_left = 24'd0; adc_right = 24'd0; adc_valid = 1'b0;
        m_en = 0; m_byp = 0; m_mix = 0; sh_dead = 0; exp_ovr = 0; exp_to = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ps_rst", 64'(ps_rst), 64'd1);
        check_eq("rst_dac_valid", 64'(dac_valid), 64'd0);
        check_eq("rst_ps_in_ready", 64'(ps_in_ready), 64'd0);
        check_eq("rst_dac", 64'({dac_left, dac_right, ps_in_left}), 64'd0);
        check_eq("rst_factor_out", 64'(shift_factor), 64'h1E00_0000);
        check_eq("rst_readdata", 64'(avs_readdata), 64'd0);
        rst = 1'b0;
        avs_rd(2'd0, d); check_eq("rst_ctrl", 64'(d), 64'd0);
        avs_rd(2'd1, d); check_eq("rst_factor", 64'(d), 64'h1E00_0000);
        avs_rd(2'd2, d); check_eq("rst_status", 64'(d), 64'd0);
        avs_rd(2'd3, d); check_eq("rst_count", 64'(d), 64'd0);

        // Shifted sample, k=4
        set_ctrl(1, 0, 0);
        sh_k = 4;
        send(24'h100000, 24'h0ABCDE, 0, 32'd0, t);
        wait_idle();
        avs_rd(2'd3, d); check_eq("count_one", 64'(d), 64'(exp_count));

        // FACTOR write together with adc_valid: sample first, then flush
        send(24'h0F0F0F, 24'hF00001, 1, 32'h2000_0000, t);
        while (cyc < t + 7 + sh_k) begin
            @(negedge clk);
            if (cyc == t + 2 + sh_k || cyc == t + 5 + sh_k)
                check_eq("flush_ps_rst_lo", 64'(ps_rst), 64'd0);
            if (cyc == t + 3 + sh_k || cyc == t + 4 + sh_k)
                check_eq("flush_ps_rst_hi", 64'(ps_rst), 64'd1);
            if (cyc == t + 3 + sh_k)
                check_eq("factor_old", 64'(shift_factor), 64'h1E00_0000);
            if (cyc == t + 4 + sh_k)
                check_eq("factor_new", 64'(shift_factor), 64'h2000_0000);
        end
        avs_rd(2'd1, d); check_eq("factor_rd", 64'(d), 64'h2000_0000);

        // Shifter never answers: timeout, dry sample out, flag set then cleared
        sh_dead = 1'b1;
        send(24'h123456, 24'h800001, 0, 32'd0, t);
        wait_idle();
        sh_dead = 1'b0;
        chk_status("timeout_status");
        avs_wr(2'd2, 32'h4);
        exp_to = 1'b0;
        chk_status("timeout_clr");

        // Second sample two cycles after the first is dropped
        sh_k = 4;
        send(24'h001111, 24'h002222, 0, 32'd0, t);
        send(24'h003333, 24'h004444, 0, 32'd0, t);
        wait_idle();
        chk_status("overrun_status");
        avs_wr(2'd2, 32'h2);
        exp_ovr = 1'b0;
        chk_status("overrun_clr");

        // Mix bit
`ifdef PITCH_CTRL_MIX_EN
        set_ctrl(1, 0, 1);
        send(24'h200000, 24'h200000, 0, 32'd0, t);
        wait_idle();
        check_eq("mix_left", 64'(dac_left), 64'h18_0000);
        set_ctrl(1, 0, 0);
`else
        avs_wr(2'd0, 32'h7);
        avs_rd(2'd0, d); check_eq("ctrl_no_mix", 64'(d), 64'h3);
        set_ctrl(1, 0, 0);
`endif

        // Mute and bypass
        set_ctrl(0, 0, 0);
        send(24'h7FFFFF, 24'h000001, 0, 32'd0, t);
        wait_idle();
        set_ctrl(1, 1, 0);
        send(24'hABCDEF, 24'h13579B, 0, 32'd0, t);
        wait_idle();
        check_eq("bypass_hold", 64'({dac_left, dac_right}), 64'h00AB_CDEF_1357_9B);

        // Randomised modes, latencies and sample spacing
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 3);
            set_ctrl(mode != 0, mode == 1, 1'($urandom_range(0, 1)));
            sh_k = $urandom_range(1, 8);
            l = 24'($urandom);
            r = 24'($urandom);
            send(l, r, 0, 32'd0, t);
            if ($urandom_range(0, 1) == 1) begin
                g = $urandom_range(0, sh_k + 3);
                repeat (g) @(negedge clk);
                send(~l, r ^ 24'h5A5A5A, 0, 32'd0, t);
            end
            wait_idle();
            chk_status("rnd_status");
            if (exp_ovr) begin
                avs_wr(2'd2, 32'h2);
                exp_ovr = 1'b0;
            end
        end
        avs_rd(2'd3, d); check_eq("rnd_count", 64'(d), 64'(exp_count));
        avs_wr(2'd3, 32'hFFFF_FFFF);
        avs_rd(2'd3, d); check_eq("count_clr", 64'(d), 64'd0);

        guard = 0;
        while ((dac_q.size() != 0 || pir_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("dac_missing", 64'(dac_q.size()), 64'd0);
        check_eq("pir_missing", 64'(pir_q.size()), 64'd0);

        // Reset in the middle of a transaction with a factor pending
        set_ctrl(1, 0, 0);
        sh_k = 8;
        send(24'h0C0C0C, 24'h0D0D0D, 0, 32'd0, t);
        avs_wr(2'd1, 32'h0AAA_AAAA);
        @(negedge clk);
        rst = 1'b1;
        dac_q.delete();
        pir_q.delete();
        repeat (2) begin
            @(negedge clk);
            check_eq("midrst_ps_rst", 64'(ps_rst), 64'd1);
        end
        rst = 1'b0;
        m_en = 0; m_byp = 0; m_mix = 0; exp_count = 0; free_cyc = 0;
        repeat (12) begin
            @(negedge clk);
            check_eq("midrst_no_flush", 64'(ps_rst), 64'd0);
        end
        check_eq("midrst_factor_out", 64'(shift_factor), 64'h1E00_0000);
        avs_rd(2'd1, d); check_eq("midrst_factor", 64'(d), 64'h1E00_0000);
        avs_rd(2'd0, d); check_eq("midrst_ctrl", 64'(d), 64'd0);
        avs_rd(2'd3, d); check_eq("midrst_count", 64'(d), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
